// File: rtl/pc_npc_unit_if.sv
// Fetch-side bundle between decode (master) and the PC/next-PC unit (slave).
// Carries the redirect requests in one direction and the fetch address/status in the other.
interface pc_npc_unit_if #(
  parameter int ADDR_W = 10
);
  logic              stall;
  logic              halt;
  logic              br_en;
  logic              br_cond;
  logic [15:0]       br_imm;
  logic              j_en;
  logic [25:0]       j_idx;
  logic              jr_en;
  logic [31:0]       jr_addr;
  logic [ADDR_W-1:0] pc_out;
  logic [ADDR_W-1:0] pc_plus4;
  logic              fetch_valid;
  logic              fault;
  logic [1:0]        state;

  modport master (
    output stall, halt, br_en, br_cond, br_imm, j_en, j_idx, jr_en, jr_addr,
    input  pc_out, pc_plus4, fetch_valid, fault, state
  );

  modport slave (
    input  stall, halt, br_en, br_cond, br_imm, j_en, j_idx, jr_en, jr_addr,
    output pc_out, pc_plus4, fetch_valid, fault, state
  );
endinterface

// File: rtl/pc_npc_unit.sv
// Program counter and next-PC selection for the instruction memory, with a
// boot/run/halt/fault controller that gates fetch validity.
module pc_npc_unit #(
  parameter int                ADDR_W   = 10,
  parameter logic [ADDR_W-1:0] RESET_PC = {ADDR_W{1'b0}}
) (
  input  logic           clk,
  input  logic           rst_pc,
  pc_npc_unit_if.slave   bus
);

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_HALT  = 2'd2,
    ST_FAULT = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              fv_q, fv_d;
  logic              fault_q, fault_d;

  logic [ADDR_W-1:0] pc_plus4_s;
  logic [ADDR_W-1:0] jr_tgt_s;
  logic [ADDR_W-1:0] j_tgt_s;
  logic [ADDR_W-1:0] br_off_s;
  logic [ADDR_W-1:0] br_tgt_s;

  assign pc_plus4_s = pc_q + {{(ADDR_W-3){1'b0}}, 3'b100};
  assign jr_tgt_s   = bus.jr_addr[ADDR_W-1:0];
  assign j_tgt_s    = {bus.j_idx[ADDR_W-3:0], 2'b00};
  // Low ADDR_W bits of the sign-extended word offset; the sign bits fall off the top.
  assign br_off_s   = {bus.br_imm[ADDR_W-3:0], 2'b00};
  assign br_tgt_s   = pc_plus4_s + br_off_s;

  logic unused_bits;
  assign unused_bits = ^{bus.jr_addr[31:ADDR_W], bus.j_idx[25:ADDR_W-2],
                         bus.br_imm[15:ADDR_W-2]};

  // Next-state and next-PC selection; inputs only matter while running.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    fv_d    = fv_q;
    fault_d = fault_q;
    case (state_q)
      ST_BOOT: begin
        state_d = ST_RUN;
        fv_d    = 1'b1;
      end
      ST_RUN: begin
        if (bus.halt) begin
          state_d = ST_HALT;
          fv_d    = 1'b0;
        end else if (bus.stall) begin
          pc_d = pc_q;
        end else if (bus.jr_en) begin
          if (jr_tgt_s[1:0] != 2'b00) begin
            state_d = ST_FAULT;
            fv_d    = 1'b0;
            fault_d = 1'b1;
          end else begin
            pc_d = jr_tgt_s;
          end
        end else if (bus.j_en) begin
          pc_d = j_tgt_s;
        end else if (bus.br_en && bus.br_cond) begin
          pc_d = br_tgt_s;
        end else begin
          pc_d = pc_plus4_s;
        end
      end
      ST_HALT, ST_FAULT: begin
        fv_d = 1'b0;
      end
      default: begin
        state_d = ST_FAULT;
        fv_d    = 1'b0;
        fault_d = 1'b1;
      end
    endcase
  end

  // State, PC and status registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst_pc) begin
    if (rst_pc) begin
      state_q <= ST_BOOT;
      pc_q    <= RESET_PC;
      fv_q    <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      fv_q    <= fv_d;
      fault_q <= fault_d;
    end
  end

  assign bus.pc_out      = pc_q;
  assign bus.pc_plus4    = pc_plus4_s;
  assign bus.fetch_valid = fv_q;
  assign bus.fault       = fault_q;
  assign bus.state       = state_q;

endmodule

// File: tb/tb_pc_npc_unit.sv
// Bench for pc_npc_unit: directed scenarios with literal expectations plus a
// randomized run compared every cycle against a behavioural model.
module tb_pc_npc_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  pc_npc_unit_if #(.ADDR_W(10)) bus ();

  pc_npc_unit dut (
    .clk    (clk),
    .rst_pc (rst),
    .bus    (bus.slave)
  );

  always #5 clk = ~clk;

  // Behavioural model: state 0 boot, 1 run, 2 halt, 3 fault; PC as plain integer mod 1024.
  int m_pc;
  int m_st;
  int m_fault;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_pc    <= 0;
      m_st    <= 0;
      m_fault <= 0;
    end else if (m_st == 0) begin
      m_st <= 1;
    end else if (m_st == 1) begin
      if (bus.halt) m_st <= 2;
      else if (bus.stall) m_pc <= m_pc;
      else if (bus.jr_en) begin
        if (bus.jr_addr % 4 != 0) begin
          m_st    <= 3;
          m_fault <= 1;
        end else m_pc <= int'(bus.jr_addr % 1024);
      end
      else if (bus.j_en) m_pc <= int'((bus.j_idx * 4) % 1024);
      else if (bus.br_en && bus.br_cond)
        m_pc <= (m_pc + 4 + 4 * int'($signed(bus.br_imm))) & 1023;
      else m_pc <= (m_pc + 4) % 1024;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    chk("model_pc_out", int'(bus.pc_out), m_pc);
    chk("model_pc_plus4", int'(bus.pc_plus4), (m_pc + 4) % 1024);
    chk("model_fetch_valid", int'(bus.fetch_valid), (m_st == 1) ? 1 : 0);
    chk("model_fault", int'(bus.fault), m_fault);
    chk("model_state", int'(bus.state), m_st);
  end

  task automatic idle();
    bus.stall = 1'b0; bus.halt = 1'b0; bus.br_en = 1'b0; bus.br_cond = 1'b0;
    bus.br_imm = 16'h0000; bus.j_en = 1'b0; bus.j_idx = 26'h0; bus.jr_en = 1'b0;
    bus.jr_addr = 32'h0;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic jump_to(input int word_idx);
    idle();
    bus.j_en = 1'b1;
    bus.j_idx = 26'(word_idx);
    tick();
    idle();
  endtask

  task automatic randomize_inputs();
    bus.stall   = ($urandom % 8 == 0);
    bus.halt    = ($urandom % 128 == 0);
    bus.jr_en   = ($urandom % 10 == 0);
    bus.jr_addr = $urandom;
    if ($urandom % 8 != 0) bus.jr_addr[1:0] = 2'b00;
    bus.j_en    = ($urandom % 10 == 0);
    bus.j_idx   = 26'($urandom);
    bus.br_en   = ($urandom % 4 == 0);
    bus.br_cond = 1'($urandom % 2);
    bus.br_imm  = 16'($urandom);
  endtask

  initial begin
    idle();
    tick();
    tick();
    chk("reset_pc", int'(bus.pc_out), 0);
    chk("reset_state", int'(bus.state), 0);
    chk("reset_fetch_valid", int'(bus.fetch_valid), 0);
    chk("reset_fault", int'(bus.fault), 0);

    rst = 1'b0;
    tick();
    chk("boot_pc", int'(bus.pc_out), 'h000);
    chk("boot_fetch_valid", int'(bus.fetch_valid), 1);
    tick();
    chk("seq_pc_1", int'(bus.pc_out), 'h004);
    tick();
    chk("seq_pc_2", int'(bus.pc_out), 'h008);

    bus.jr_en = 1'b1; bus.jr_addr = 32'h0000_03FC;
    tick();
    idle();
    chk("jr_top_pc", int'(bus.pc_out), 'h3FC);
    chk("top_pc_plus4_wrap", int'(bus.pc_plus4), 'h000);
    tick();
    chk("wrap_pc", int'(bus.pc_out), 'h000);
    chk("wrap_fault", int'(bus.fault), 0);

    jump_to(4);
    chk("j_pc", int'(bus.pc_out), 'h010);
    bus.br_en = 1'b1; bus.br_cond = 1'b1; bus.br_imm = 16'hFFFE;
    tick();
    idle();
    chk("br_taken_pc", int'(bus.pc_out), 'h00C);
    jump_to(4);
    bus.br_en = 1'b1; bus.br_cond = 1'b0; bus.br_imm = 16'hFFFE;
    tick();
    idle();
    chk("br_not_taken_pc", int'(bus.pc_out), 'h014);

    bus.jr_en = 1'b1; bus.jr_addr = 32'h40; bus.j_en = 1'b1; bus.j_idx = 26'd5;
    bus.br_en = 1'b1; bus.br_cond = 1'b1; bus.br_imm = 16'h0010;
    tick();
    chk("prio_jr_pc", int'(bus.pc_out), 'h040);
    bus.jr_addr = 32'h80; bus.stall = 1'b1;
    tick();
    idle();
    chk("prio_stall_pc", int'(bus.pc_out), 'h040);
    chk("prio_stall_valid", int'(bus.fetch_valid), 1);

    bus.jr_en = 1'b1; bus.jr_addr = 32'h102;
    tick();
    idle();
    chk("fault_state", int'(bus.state), 3);
    chk("fault_flag", int'(bus.fault), 1);
    chk("fault_valid", int'(bus.fetch_valid), 0);
    for (int i = 0; i < 10; i++) begin
      randomize_inputs();
      tick();
    end
    idle();
    chk("fault_frozen_pc", int'(bus.pc_out), 'h040);
    #2 rst = 1'b1;
    #1;
    chk("fault_reset_pc", int'(bus.pc_out), 0);
    chk("fault_reset_flag", int'(bus.fault), 0);
    chk("fault_reset_state", int'(bus.state), 0);
    #1 rst = 1'b0;

    tick();
    jump_to(8);
    chk("halt_setup_pc", int'(bus.pc_out), 'h020);
    bus.halt = 1'b1; bus.stall = 1'b1;
    tick();
    idle();
    chk("halt_state", int'(bus.state), 2);
    chk("halt_pc", int'(bus.pc_out), 'h020);
    chk("halt_valid", int'(bus.fetch_valid), 0);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async_reset_pc", int'(bus.pc_out), 0);
    chk("async_reset_state", int'(bus.state), 0);
    chk("async_reset_valid", int'(bus.fetch_valid), 0);
    @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 3000; i++) begin
      randomize_inputs();
      tick();
      if (m_st >= 2 && $urandom % 4 == 0) begin
        #2 rst = 1'b1;
        #1 rst = 1'b0;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
